// File: rtl/sysid_pkg.sv
// Shared register map and bit positions for the system-identification slave.
package sysid_pkg;

    localparam logic [3:0] ADDR_ID       = 4'd0;
    localparam logic [3:0] ADDR_TS       = 4'd1;
    localparam logic [3:0] ADDR_UPLO     = 4'd2;
    localparam logic [3:0] ADDR_UPHI     = 4'd3;
    localparam logic [3:0] ADDR_CTRL     = 4'd4;
    localparam logic [3:0] ADDR_STATUS   = 4'd5;
    localparam logic [3:0] ADDR_SCRATCH0 = 4'd6;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;
    localparam int STATUS_OVF_BIT = 0;

    localparam int MIN_UPTIME_WIDTH = 32;
    localparam int MAX_UPTIME_WIDTH = 64;
    localparam int MAX_SCRATCH      = 10;

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with enable, synchronous clear and a sticky
// overflow flag that is set on the edge the counter wraps to zero.
module sysid_uptime_ctr #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_wr,
    input  logic             en_wdata,
    input  logic             clr,
    input  logic             ovf_w1c,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             en,
    output logic             ovf
);

    // High on the edge that takes the counter from all-ones back to zero.
    assign wrap_pulse = en && !clr && (&count);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            en    <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            if (clr) begin
                count <= '0;
            end else if (en) begin
                count <= count + WIDTH'(1);
            end

            if (ctrl_wr) begin
                en <= en_wdata;
            end

            if (wrap_pulse) begin
                ovf <= 1'b1;
            end else if (ovf_w1c) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sysid_info_regs.sv
// System-identification Avalon-MM slave: ID/timestamp words, uptime counter
// with coherent 64-bit snapshot, control/status and scratch registers.
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h5872_0E99,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          UPTIME_WIDTH = 48,
    parameter int          NUM_SCRATCH  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [3:0]              byteenable,
    output logic [31:0]             readdata,
    output logic                    readdatavalid,
    output logic [UPTIME_WIDTH-1:0] uptime
);

    if (UPTIME_WIDTH < MIN_UPTIME_WIDTH || UPTIME_WIDTH > MAX_UPTIME_WIDTH) begin : g_bad_width
        $fatal(1, "sysid_info_regs: UPTIME_WIDTH must be within 32..64");
    end
    if (NUM_SCRATCH < 1 || NUM_SCRATCH > MAX_SCRATCH) begin : g_bad_scratch
        $fatal(1, "sysid_info_regs: NUM_SCRATCH must be within 1..10");
    end

    logic [UPTIME_WIDTH-1:0] count;
    logic [63:0]             count_ext;
    logic                    ctr_en;
    logic                    ctr_ovf;
    logic                    wrap_pulse;
    logic                    wr_eff;
    logic                    ctrl_wr;
    logic                    ctr_clr;
    logic                    ovf_w1c;
    logic [31:0]             shadow;
    logic [31:0]             scratch [NUM_SCRATCH];
    logic [31:0]             rd_mux;

    // A read in the same cycle as a write wins; the write is dropped.
    assign wr_eff  = write && !read;
    assign ctrl_wr = wr_eff && (address == ADDR_CTRL) && byteenable[0];
    assign ctr_clr = ctrl_wr && writedata[CTRL_CLR_BIT];
    // A wrap on the same edge keeps ovf set, so the clear is suppressed.
    assign ovf_w1c = wr_eff && (address == ADDR_STATUS) && byteenable[0]
                     && writedata[STATUS_OVF_BIT] && !wrap_pulse;

    sysid_uptime_ctr #(
        .WIDTH (UPTIME_WIDTH)
    ) u_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_wr    (ctrl_wr),
        .en_wdata   (writedata[CTRL_EN_BIT]),
        .clr        (ctr_clr),
        .ovf_w1c    (ovf_w1c),
        .count      (count),
        .wrap_pulse (wrap_pulse),
        .en         (ctr_en),
        .ovf        (ctr_ovf)
    );

    assign uptime    = count;
    assign count_ext = 64'(count);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:     rd_mux = ID_VALUE;
            ADDR_TS:     rd_mux = TIMESTAMP;
            ADDR_UPLO:   rd_mux = count_ext[31:0];
            ADDR_UPHI:   rd_mux = shadow;
            ADDR_CTRL:   rd_mux[CTRL_EN_BIT] = ctr_en;
            ADDR_STATUS: rd_mux[STATUS_OVF_BIT] = ctr_ovf;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == 4'(int'(ADDR_SCRATCH0) + i)) begin
                        rd_mux = scratch[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            shadow        <= '0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
            // Upper half is captured from the same pre-increment value as LO.
            if (read && address == ADDR_UPLO) begin
                shadow <= count_ext[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_eff && byteenable[b] && address == 4'(int'(ADDR_SCRATCH0) + i)) begin
                        scratch[i][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_info_regs.sv
// Scoreboard bench for sysid_info_regs: a behavioural register model predicts
// read data and the uptime tap; a negedge monitor checks every cycle.
module tb_sysid_info_regs;

    localparam logic [31:0] ID  = 32'h5872_0E99;
    localparam logic [31:0] TS  = 32'h2024_0611;
    localparam int          W   = 48;
    localparam int          NS  = 2;
    localparam logic [63:0] CNT_MAX = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - W);

    logic          clk;
    logic          reset_n;
    logic [3:0]    address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic [W-1:0]  uptime;

    sysid_info_regs #(
        .ID_VALUE     (ID),
        .TIMESTAMP    (TS),
        .UPTIME_WIDTH (W),
        .NUM_SCRATCH  (NS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .uptime        (uptime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model of the register file
    logic [63:0] m_cnt;
    bit          m_en;
    bit          m_ovf;
    logic [31:0] m_shadow;
    logic [31:0] m_scr [NS];

    task automatic model_reset();
        m_cnt    = '0;
        m_en     = 1'b1;
        m_ovf    = 1'b0;
        m_shadow = '0;
        for (int i = 0; i < NS; i++) m_scr[i] = '0;
    endtask

    function automatic logic [31:0] model_read(int addr);
        case (addr)
            0: return ID;
            1: return TS;
            2: return m_cnt[31:0];
            3: return m_shadow;
            4: return {31'b0, m_en};
            5: return {31'b0, m_ovf};
            default: return (addr >= 6 && addr < 6 + NS) ? m_scr[addr-6] : 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge given the bus inputs at that edge.
    task automatic model_step(bit rd, bit wr, int addr, logic [31:0] wd, logic [3:0] be);
        bit          wr_eff;
        bit          clr;
        bit          wrap;
        logic [63:0] nxt;
        wr_eff = wr && !rd;
        if (rd) begin
            exp_q.push_back('{model_read(addr), addr});
            if (addr == 2) m_shadow = m_cnt[63:32];
        end
        clr  = wr_eff && addr == 4 && be[0] && wd[1];
        wrap = !clr && m_en && m_cnt == CNT_MAX;
        if (clr)       nxt = '0;
        else if (m_en) nxt = (m_cnt == CNT_MAX) ? 64'd0 : m_cnt + 64'd1;
        else           nxt = m_cnt;
        if (wr_eff && addr == 4 && be[0]) m_en = wd[0];
        if (wrap) m_ovf = 1'b1;
        else if (wr_eff && addr == 5 && be[0] && wd[0]) m_ovf = 1'b0;
        if (wr_eff && addr >= 6 && addr < 6 + NS) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_scr[addr-6][8*b +: 8] = wd[8*b +: 8];
        end
        m_cnt = nxt;
    endtask

    // Entered and left at posedge+1; one call is exactly one clock cycle.
    task automatic bus(bit rd, bit wr, int addr, logic [31:0] wd, logic [3:0] be);
        read       = rd;
        write      = wr;
        address    = addr[3:0];
        writedata  = wd;
        byteenable = be;
        @(posedge clk);
        model_step(rd, wr, addr, wd, be);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) bus(0, 0, 0, 32'h0, 4'h0);
    endtask

    task automatic force_cnt(logic [63:0] v);
        force dut.u_ctr.count = v[W-1:0];
        m_cnt = v;
        #1;
        release dut.u_ctr.count;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read must produce valid at exactly the next negedge.
    always @(negedge clk) begin
        if (reset_n) begin
            vectors++;
            if (readdatavalid) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_valid: readdatavalid=1 with no read outstanding, readdata=%h", readdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (readdata !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL readdata addr %0d: got %h expected %h", mon_e.addr, readdata, mon_e.data);
                    end
                end
            end else if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL missing_valid addr %0d: readdatavalid=0 expected 1", exp_q[0].addr);
                exp_q.delete();
            end
            vectors++;
            if (uptime !== m_cnt[W-1:0]) begin
                miscompares++;
                $display("FAIL uptime: got %h expected %h", uptime, m_cnt[W-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int a;
        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(readdatavalid), 64'd0);
        chk("reset_rdata", 64'(readdata), 64'd0);
        chk("reset_uptime", 64'(uptime), 64'd0);
        reset_n = 1'b1;

        // ID, timestamp, scratch, unmapped and control reset values
        bus(1, 0, 0, 0, 0);
        bus(1, 0, 1, 0, 0);
        bus(1, 0, 7, 0, 0);
        bus(1, 0, 15, 0, 0);
        idle(1);
        bus(1, 0, 4, 0, 0);
        idle(1);
        bus(1, 0, 5, 0, 0);
        bus(1, 0, 3, 0, 0);
        bus(1, 0, 8, 0, 0);
        idle(2);

        // Byte-lane writes, ignored address, read-over-write priority
        bus(0, 1, 6, 32'h1111_1111, 4'hF);
        bus(0, 1, 6, 32'hDEAD_BEEF, 4'b0101);
        bus(0, 1, 15, 32'hFFFF_FFFF, 4'hF);
        bus(1, 0, 6, 0, 0);
        bus(1, 1, 7, 32'hA5A5_A5A5, 4'hF);
        bus(1, 0, 7, 0, 0);
        bus(1, 0, 15, 0, 0);
        idle(1);

        // Snapshot: LO read latches HI; shadow does not follow the live counter
        force_cnt(64'h0000_FFFF_FFFF);
        bus(1, 0, 2, 0, 0);
        idle(5);
        bus(1, 0, 3, 0, 0);
        bus(1, 0, 2, 0, 0);
        bus(1, 0, 3, 0, 0);
        idle(1);

        // Freeze with en=0, then clear and restart
        bus(0, 1, 4, 32'h0, 4'hF);
        idle(100);
        bus(1, 0, 2, 0, 0);
        bus(1, 0, 4, 0, 0);
        bus(0, 1, 4, 32'h3, 4'hF);
        bus(1, 0, 2, 0, 0);
        idle(5);
        bus(1, 0, 2, 0, 0);
        bus(1, 0, 4, 0, 0);

        // Overflow: wrap sets ovf, W1C on a wrap edge loses, later W1C clears
        force_cnt(CNT_MAX);
        idle(1);
        bus(1, 0, 5, 0, 0);
        force_cnt(CNT_MAX);
        bus(0, 1, 5, 32'h1, 4'h1);
        bus(1, 0, 5, 0, 0);
        bus(0, 1, 5, 32'h1, 4'h0);
        bus(1, 0, 5, 0, 0);
        bus(0, 1, 5, 32'h1, 4'h1);
        bus(1, 0, 5, 0, 0);
        bus(1, 0, 2, 0, 0);
        bus(1, 0, 3, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 5);
            a  = $urandom_range(0, 15);
            case (op)
                0:       idle(1);
                1, 2:    bus(1, 0, a, 0, 0);
                3:       bus(0, 1, a, $urandom, 4'($urandom_range(0, 15)));
                4:       bus(0, 1, 4, {$urandom_range(0, 1) == 0 ? 31'h0 : 31'h1, 1'b1}, 4'hF);
                default: bus(1, 1, a, $urandom, 4'hF);
            endcase
        end
        idle(2);

        // Reset while a read result is on the bus
        bus(0, 1, 6, 32'hCAFE_F00D, 4'hF);
        bus(0, 1, 4, 32'h0, 4'hF);
        bus(0, 1, 5, 32'h0, 4'hF);
        bus(1, 0, 6, 0, 0);
        reset_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        chk("rst_kill_valid", 64'(readdatavalid), 64'd0);
        @(negedge clk);
        chk("rst_valid_negedge", 64'(readdatavalid), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_valid_late", 64'(readdatavalid), 64'd0);
        chk("rst_rdata", 64'(readdata), 64'd0);
        chk("rst_uptime", 64'(uptime), 64'd0);
        reset_n = 1'b1;
        bus(1, 0, 6, 0, 0);
        bus(1, 0, 7, 0, 0);
        bus(1, 0, 4, 0, 0);
        bus(1, 0, 5, 0, 0);
        bus(1, 0, 3, 0, 0);
        bus(1, 0, 2, 0, 0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
